// File: rtl/multicycle_controller.sv
// Moore FSM sequencer for the multicycle MIPS-lite datapath: drives every
// datapath select/enable per state and arbitrates the shared memory handshake.
module multicycle_controller #(
    parameter logic [3:0]  RESET_STATE = 4'd0,
    parameter int unsigned MAX_WAIT    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       extsel,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic       instr_done,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RCOMP = 4'd7,
        BRANCH = 4'd8,  JUMP   = 4'd9,  ORIEX  = 4'd10, ORIWB = 4'd11,
        TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ORI = 6'b001101;

    localparam int unsigned    CW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0]  WAIT_LAST = (MAX_WAIT == 0) ? '0 : CW'(MAX_WAIT - 1);

    state_t        cur, nxt;
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          timeout;

    // The cycle that would be the MAX_WAIT-th stalled cycle diverts to TRAP.
    always_comb begin
        waiting = ((cur == FETCH) || (cur == MEMRD) || (cur == MEMWR)) && !mem_ready;
        timeout = waiting && (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= state_t'(RESET_STATE);
            wait_cnt <= '0;
        end else begin
            cur <= nxt;
            if (!waiting || (nxt != cur))
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt         = cur;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        extsel      = 1'b0;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        instr_done  = 1'b0;
        trap        = 1'b0;

        unique case (cur)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready) nxt = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                unique case (opcode)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
                    OP_ORI:       nxt = ORIEX;
                    default:      nxt = TRAP;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) nxt = MEMWB;
            end
            MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            MEMWR: begin
                memwrite   = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) nxt = FETCH;
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                nxt     = RCOMP;
            end
            RCOMP: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                instr_done  = 1'b1;
                nxt         = FETCH;
            end
            JUMP: begin
                pcwrite    = 1'b1;
                pcsource   = 2'b10;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                extsel  = 1'b1;
                aluop   = 2'b11;
                nxt     = ORIWB;
            end
            ORIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
                nxt  = TRAP;
            end
            default: nxt = TRAP;
        endcase

        if (timeout) nxt = TRAP;
    end

    always_comb state = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed corner sequences,
// a CPI vector table and randomized instruction streams against a path model.
module tb_multicycle_controller;

    localparam int MAX_WAIT = 8;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] ORI = 6'b001101;
    localparam logic [5:0] BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] opcode;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, extsel, instr_done, trap;
    logic [1:0] alusrcb, aluop, pcsource;
    logic [3:0] state;

    multicycle_controller #(.RESET_STATE(4'd0), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .extsel(extsel),
        .aluop(aluop), .pcsource(pcsource), .instr_done(instr_done), .trap(trap),
        .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Control word layout: pcw pcwc iord mrd mwr irw m2r rdst rw asa asb[2] ext aop[2] psrc[2] idone trap
    function automatic logic [18:0] mk(input logic a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw,
                                       a_m2r, a_rdst, a_rw, a_asa, input logic [1:0] a_asb,
                                       input logic a_ext, input logic [1:0] a_aop, a_psrc,
                                       input logic a_idn, a_trp);
        return {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_asa,
                a_asb, a_ext, a_aop, a_psrc, a_idn, a_trp};
    endfunction

    function automatic logic [18:0] ctl_now();
        return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
                regwrite, alusrca, alusrcb, extsel, aluop, pcsource, instr_done, trap};
    endfunction

    logic [18:0] ctl_tab [13];

    function automatic logic [18:0] exp_ctl(input int st, input logic mr);
        logic [18:0] v;
        v = ctl_tab[st];
        if (st == 0 && mr) v = v | mk(1,0,0,0,0,1,0,0,0,0,2'b00,0,2'b00,2'b00,0,0);
        if (st == 5 && mr) v = v | mk(0,0,0,0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0);
        return v;
    endfunction

    // Reference model: per-instruction list of visited states; memory states stretch on stalls.
    int   path[$];
    int   pidx, wcnt;
    bit   mtrap, inst_end;
    logic [5:0] cur_op;
    logic       cur_z;

    function automatic int mstate();
        return mtrap ? 12 : path[pidx];
    endfunction

    task automatic mreset();
        path = '{0};
        pidx = 0; wcnt = 0; mtrap = 0; inst_end = 0;
    endtask

    task automatic begin_instr(input logic [5:0] op, input logic z);
        cur_op = op; cur_z = z; inst_end = 0; pidx = 0;
        path = '{0, 1};
        case (op)
            LW:      begin path.push_back(2); path.push_back(3); path.push_back(4); end
            SW:      begin path.push_back(2); path.push_back(5); end
            RT:      begin path.push_back(6); path.push_back(7); end
            BEQ:     path.push_back(8);
            JMP:     path.push_back(9);
            ORI:     begin path.push_back(10); path.push_back(11); end
            default: path.push_back(12);
        endcase
    endtask

    task automatic madvance(input logic mr);
        int st;
        if (mtrap) return;
        st = path[pidx];
        if ((st == 0 || st == 3 || st == 5) && !mr) begin
            wcnt++;
            if (MAX_WAIT != 0 && wcnt == MAX_WAIT) mtrap = 1;
        end else begin
            wcnt = 0;
            pidx++;
            if (pidx == path.size()) begin
                pidx = 0;
                inst_end = 1;
            end else if (path[pidx] == 12) begin
                mtrap = 1;
            end
        end
    endtask

    int idone_cnt;

    // Entered just after a negedge; leaves at the next negedge.
    task automatic mcycle(input logic mr);
        opcode = cur_op; zero = cur_z; mem_ready = mr;
        #1;
        chk("model_state", state, mstate());
        chk("model_ctl", ctl_now(), exp_ctl(mstate(), mr));
        if (instr_done === 1'b1) idone_cnt++;
        madvance(mr);
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input bit rnd, output int cycles);
        logic mr;
        cycles = 0;
        idone_cnt = 0;
        begin_instr(op, z);
        while (!inst_end && !mtrap && cycles < 40) begin
            mr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (wcnt >= 5) mr = 1'b1;
            mcycle(mr);
            cycles++;
        end
        if (cycles >= 40) chk("instr_bound", cycles, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mreset();
    endtask

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         cpi;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        tab[7];
        logic [3:0]  lw_st[8];
        logic        lw_mr[8];
        logic [3:0]  exp4[4];
        int          cyc, cnt, fcnt;
        bit          hit;

        ctl_tab[0]  = mk(0,0,0,1,0,0,0,0,0,0,2'b01,0,2'b00,2'b00,0,0);
        ctl_tab[1]  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,0,2'b00,2'b00,0,0);
        ctl_tab[2]  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,2'b00,0,0);
        ctl_tab[3]  = mk(0,0,1,1,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0);
        ctl_tab[4]  = mk(0,0,0,0,0,0,1,0,1,0,2'b00,0,2'b00,2'b00,1,0);
        ctl_tab[5]  = mk(0,0,1,0,1,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0);
        ctl_tab[6]  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,0,2'b10,2'b00,0,0);
        ctl_tab[7]  = mk(0,0,0,0,0,0,0,1,1,0,2'b00,0,2'b00,2'b00,1,0);
        ctl_tab[8]  = mk(0,1,0,0,0,0,0,0,0,1,2'b00,0,2'b01,2'b01,1,0);
        ctl_tab[9]  = mk(1,0,0,0,0,0,0,0,0,0,2'b00,0,2'b00,2'b10,1,0);
        ctl_tab[10] = mk(0,0,0,0,0,0,0,0,0,1,2'b10,1,2'b11,2'b00,0,0);
        ctl_tab[11] = mk(0,0,0,0,0,0,0,0,1,0,2'b00,0,2'b00,2'b00,1,0);
        ctl_tab[12] = mk(0,0,0,0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1);

        tab[0] = '{LW,  1'b0, 5};
        tab[1] = '{SW,  1'b0, 4};
        tab[2] = '{RT,  1'b1, 4};
        tab[3] = '{ORI, 1'b0, 4};
        tab[4] = '{BEQ, 1'b1, 3};
        tab[5] = '{BEQ, 1'b0, 3};
        tab[6] = '{JMP, 1'b1, 3};

        // Reset held two cycles, released with mem_ready high
        reset = 1'b1; mem_ready = 1'b1; opcode = RT; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", state, 4'd0);
        chk("rst_trap", trap, 1'b0);
        chk("rst_idone", instr_done, 1'b0);
        reset = 1'b0;
        #1;
        chk("fetch_irwrite", irwrite, 1'b1);
        chk("fetch_pcwrite", pcwrite, 1'b1);
        chk("fetch_memread", memread, 1'b1);
        chk("fetch_alusrcb", alusrcb, 2'b01);
        @(negedge clk);
        #1;
        chk("post_fetch_state", state, 4'd1);
        @(negedge clk);

        // lw with two stall cycles in MEMRD
        do_reset();
        lw_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        lw_mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            opcode = LW; mem_ready = lw_mr[i];
            #1;
            chk($sformatf("lw_state%0d", i), state, lw_st[i]);
            chk($sformatf("lw_wb%0d", i), {regwrite, memtoreg}, (i == 6) ? 2'b11 : 2'b00);
            if (i < 7 && instr_done === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("lw_idone_pulses", cnt, 1);

        // beq taken and not taken
        do_reset();
        for (int zz = 1; zz >= 0; zz--) begin
            for (int i = 0; i < 3; i++) begin
                opcode = BEQ; zero = zz[0]; mem_ready = 1'b1;
                #1;
                chk("beq_state", state, (i == 2) ? 4'd8 : 4'(i));
                if (i == 2) begin
                    chk("beq_pcwritecond", pcwritecond, 1'b1);
                    chk("beq_pcsource", pcsource, 2'b01);
                    chk("beq_pcwrite", pcwrite, 1'b0);
                end
                @(negedge clk);
            end
        end

        // ori
        do_reset();
        exp4 = '{4'd0, 4'd1, 4'd10, 4'd11};
        for (int i = 0; i < 4; i++) begin
            opcode = ORI; mem_ready = 1'b1;
            #1;
            chk("ori_state", state, exp4[i]);
            if (i == 2) chk("ori_ex", {extsel, aluop}, 3'b111);
            if (i == 3) chk("ori_wb", {regwrite, regdst}, 2'b10);
            @(negedge clk);
        end

        // Illegal opcode traps; trap holds regardless of inputs
        do_reset();
        for (int i = 0; i < 6; i++) begin
            opcode = BAD; mem_ready = 1'(i % 2 == 0);
            #1;
            if (i >= 2) begin
                chk("illegal_state", state, 4'd12);
                chk("illegal_ctl", ctl_now(), 19'h1);
            end
            @(negedge clk);
        end

        // Memory timeout in FETCH
        do_reset();
        mem_ready = 1'b0; opcode = RT;
        fcnt = 0; hit = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (state == 4'd12) begin
                hit = 1;
                break;
            end
            fcnt++;
            @(negedge clk);
        end
        chk("timeout_reached", hit, 1'b1);
        chk("timeout_wait_cycles", fcnt, MAX_WAIT);
        chk("timeout_ctl", ctl_now(), 19'h1);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("timeout_sticky", {state, trap}, {4'd12, 1'b1});
        @(negedge clk);
        do_reset();
        #1;
        chk("trap_cleared", {state, trap}, {4'd0, 1'b0});

        // sw interrupted by reset while waiting in MEMWR
        for (int i = 0; i < 3; i++) begin
            opcode = SW; mem_ready = 1'b1;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        chk("sw_memwr", {state, memwrite, instr_done}, {4'd5, 1'b1, 1'b0});
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("sw_rst_state", state, 4'd0);
        chk("sw_rst_nowrite", {memwrite, instr_done}, 2'b00);
        @(negedge clk);

        // CPI table with mem_ready always high
        do_reset();
        foreach (tab[k]) begin
            run_instr(tab[k].op, tab[k].z, 1'b0, cyc);
            chk($sformatf("cpi_op%02h", tab[k].op), cyc, tab[k].cpi);
            chk($sformatf("idone_op%02h", tab[k].op), idone_cnt, 1);
        end

        // Randomized instruction stream with random memory stalls
        do_reset();
        for (int n = 0; n < 200; n++) begin
            logic [5:0] ops[6];
            ops = '{LW, SW, RT, BEQ, JMP, ORI};
            run_instr(ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), 1'b1, cyc);
            if (idone_cnt != 1) chk("rand_idone", idone_cnt, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM sequencer that turns the MIPS-lite datapath into a multicycle machine.
- One shared byte-addressed memory serves both instruction fetch and data access, using a ready/wait handshake.
- Per state, it drives every datapath select and enable: PC, IR, register file, ALU source muxes and memory.
- Sits beside the datapath and replaces the single-cycle combinational control and the PC update logic.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).
- MAX_WAIT, 8, memory wait cycles before the timeout trap; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction bits [31:26], from the IR (valid from DECODE onward).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current read/write this cycle.
- pcwrite  out  1  unconditional PC load.
- pcwritecond  out  1  PC load qualified by zero (beq).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  IR load.
- memtoreg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- regdst  out  1  write register select: 0 = rt, 1 = rd.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- extsel  out  1  1 = zero-extend imm (ori).
- aluop  out  2  00 = add, 01 = sub, 10 = use funct, 11 = or.
- pcsource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump address.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- trap  out  1  sticky; set on illegal opcode or memory timeout.
- state  out  4  current state, for debug.

Behaviour:
- Reset: state = FETCH. All outputs are decoded from state, so they take FETCH values; instr_done = 0, trap = 0, wait counter = 0. Reset wins over every other event, including mid-instruction and in TRAP.
- States: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 RCOMP, 8 BRANCH, 9 JUMP, 10 ORIEX, 11 ORIWB, 12 TRAP.
- FETCH: memread = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = 00, pcsource = 00.
  - irwrite and pcwrite assert only when mem_ready = 1. The state holds until then.
  - mem_ready = 1 -> DECODE.
- DECODE: alusrca = 0, alusrcb = 11, aluop = 00 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXEC.
  - 000100 (beq) -> BRANCH.
  - 000010 (j) -> JUMP.
  - 001101 (ori) -> ORIEX.
  - any other opcode -> TRAP.
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. Next: lw -> MEMRD; sw -> MEMWR.
- MEMRD: memread = 1, iord = 1. Holds until mem_ready, then -> MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, regdst = 0, instr_done = 1 -> FETCH.
- MEMWR: memwrite = 1, iord = 1. Holds until mem_ready. On that cycle instr_done = 1 and next state is FETCH.
- EXEC: alusrca = 1, alusrcb = 00, aluop = 10 -> RCOMP.
- RCOMP: regwrite = 1, regdst = 1, memtoreg = 0, instr_done = 1 -> FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, aluop = 01, pcwritecond = 1, pcsource = 01, instr_done = 1 -> FETCH. The PC loads only if zero = 1.
- JUMP: pcwrite = 1, pcsource = 10, instr_done = 1 -> FETCH.
- ORIEX: alusrca = 1, alusrcb = 10, extsel = 1, aluop = 11 -> ORIWB.
- ORIWB: regwrite = 1, regdst = 0, memtoreg = 0, instr_done = 1 -> FETCH.
- TRAP: all enables are 0 and trap = 1. Exit only via reset.
- Idle default: any output not listed for a state is 0.
- Wait counter:
  - Counts consecutive cycles with mem_ready = 0 in FETCH, MEMRD or MEMWR.
  - Clears on mem_ready = 1 and on any state change.
  - Reaching MAX_WAIT (when MAX_WAIT != 0) -> TRAP on the next edge.
- Write-enable guarantee: memwrite and regwrite are never asserted in the same cycle. At most one of pcwrite/pcwritecond is asserted per cycle.
- CPI (mem_ready always 1): lw 5, sw 4, R-type 4, ori 4, beq 3, j 3.

Test Plan:
- Reset held 2 cycles, then released with mem_ready = 1 -> state = 0 and trap = 0 during reset. First cycle after release: irwrite = pcwrite = 1, memread = 1, alusrcb = 01.
- lw (opcode 100011) with mem_ready low for 2 cycles in MEMRD -> state sequence 0, 1, 2, 3, 3, 3, 4, 0. regwrite = 1 with memtoreg = 1 only in state 4. instr_done pulses once.
- beq (000100) with zero = 1, then again with zero = 0 -> state 8 both times with pcwritecond = 1, pcsource = 01. 3 cycles per instruction; the PC-load decision is left to the datapath AND.
- ori (001101) -> states 0, 1, 10, 11. extsel = 1 and aluop = 11 in state 10; regwrite = 1, regdst = 0 in state 11.
- Illegal opcode 111111, then MAX_WAIT = 8 with mem_ready stuck at 0 in FETCH -> state 12 with trap = 1 and no enables in both cases. The timeout reaches TRAP after 8 wait cycles; only reset clears trap.
- sw (101011) with reset asserted in state 5 while mem_ready = 0 -> next state is 0, no memwrite after the reset edge, instr_done stays 0.
